seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
Parametrised single-bus datapath with a built-in micro-step sequencer. It executes one register-level command at a time: ALU ops, immediate add, load/store, I/O and HI/LO moves. Commands arrive over a valid/ready handshake, memory traffic uses a req/ack handshake, and completion is signalled by a done pulse. It sits between the instruction decoder (command source) and the memory/I-O subsystem.

Parameters:
DATA_WIDTH, 32, width of bus, registers, memory address and data
NUM_REGS, 16, number of general-purpose registers (power of 2, min 2)
REG_AW, $clog2(NUM_REGS), derived localparam, register index width

Ports:
clock  in  1  single clock, rising edge
clear  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted on valid&ready edge
cmd_op  in  4  opcode (see Behaviour)
cmd_ra  in  REG_AW  destination register
cmd_rb  in  REG_AW  source A / base / out-source
cmd_rc  in  REG_AW  source B / store data / shift amount
cmd_imm  in  DATA_WIDTH  immediate / address offset
mem_addr  out  DATA_WIDTH  MAR contents
mem_wdata  out  DATA_WIDTH  MDR contents
mem_rd  out  1  read request
mem_wr  out  1  write request
mem_ack  in  1  memory completes current request
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
inport_data  in  DATA_WIDTH  input port
outport_data  out  DATA_WIDTH  output port register
done  out  1  one-cycle completion pulse
illegal  out  1  qualifies done for undefined opcode
hi_value, lo_value  out  DATA_WIDTH each  HI/LO registers
bus_value  out  DATA_WIDTH  current internal bus
dbg_rsel  in  REG_AW  debug read index
dbg_rdata  out  DATA_WIDTH  GPR[dbg_rsel], combinational

Behaviour:
- Reset (clear low, async): all GPRs, Y, Z (2W), MAR, MDR, HI, LO, and outport are 0. State is IDLE; done, illegal, mem_rd and mem_wr are 0; cmd_ready is 1. Reset mid-operation aborts at once; mem_rd/mem_wr drop asynchronously.
- Opcodes: 0 ADD, 1 SUB (rb-rc), 2 AND, 3 OR, 4 SHL, 5 SHR logical, 6 MUL signed, 7 ADDI (rb+imm), 8 LD ra<=M[rb+imm], 9 ST M[rb+imm]<=rc, 10 IN ra<=inport, 11 OUT outport<=rb, 12 MFHI, 13 MFLO, 14-15 illegal.
- States: IDLE, LOADY (bus=GPR[rb], Y<=bus), ALU (bus=GPR[rc] or imm, Z<=alu(Y,bus)), WB, MAR (bus=Zlo, MAR<=bus), MDR (bus=GPR[rc], MDR<=bus), WAIT, MEMWB.
- Command fields are latched on acceptance. cmd_ready is 1 only in IDLE. cmd_valid while busy is ignored, and the source holds the command.
- Sequences:
  - ALU ops / ADDI: LOADY, ALU, WB (ra<=Zlo).
  - MUL: LOADY, ALU, WB (HI<=Zhi, LO<=Zlo, ra untouched).
  - LD: LOADY, ALU, MAR, WAIT (MDR<=mem_rdata on ack), MEMWB (ra<=MDR).
  - ST: LOADY, ALU, MAR, MDR, WAIT.
  - IN/OUT/MFHI/MFLO: WB only.
  - Illegal: WB with no write; illegal=1 alongside done.
- done is registered and asserted in the first IDLE cycle after the last step. A new command may be accepted in that same cycle.
- Latency (accept edge = cycle 0, done cycle): ALU ops 4; I/O and HI/LO moves 2; LD/ST 6 when mem_ack arrives in the first WAIT cycle, plus 1 per extra wait cycle.
- Memory handshake:
  - mem_rd (LD) or mem_wr (ST) is high in every WAIT cycle and drops the cycle after mem_ack is sampled high.
  - mem_addr=MAR and mem_wdata=MDR stay stable throughout.
  - mem_ack outside WAIT is ignored. There is no timeout.
- Arithmetic: ADD/SUB/ADDI wrap modulo 2^DATA_WIDTH, with no flags. Shift amount is rc[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored. MUL produces a full 2W signed product. Non-MUL ops zero Zhi.
- Register sources are read before the destination is written, so ra==rb or ra==rc is legal.

Decomposition:
- seq_datapath_pkg holds the opcode localparams, the state encoding, and the bus-source select encoding.
- One natural sub-module: seq_datapath_alu. It is combinational, takes op, Y and bus, and returns a 2*DATA_WIDTH result.
- GPRs are an array indexed by REG_AW; the bus is an encoded mux, not one-hot.

Test Plan:
- Reset, then IN ra=1 with inport=0x00000005 -> done at cycle 2; dbg r1=0x00000005.
- r1=5, r2=0xFFFFFFFE; ADD ra=3 -> r3=0x00000003 with done 4 cycles after accept. Back-to-back SUB ra=4 accepted in the done cycle -> r4=0x00000007.
- r1=0xFFFFFFFD, r2=7; MUL, then MFHI r5 and MFLO r6 -> r5=0xFFFFFFFF, r6=0xFFFFFFEB; the MUL's ra is unchanged.
- r1=0x5, r2=0xCAFEF00D; ST rb=1, rc=2, imm=0x10, ack delayed 3 cycles -> mem_wr high exactly 4 cycles, addr 0x15, wdata 0xCAFEF00D, done at cycle 9. LD ra=7 same address with rdata 0xDEADBEEF -> r7=0xDEADBEEF.
- r1=0x1, r2=0x21; SHL ra=3 -> r3=0x00000002 (shift by 1). Opcode 15 -> done with illegal=1 at cycle 2 and no register changes.
- clear pulled low during LD WAIT -> mem_rd drops immediately and all registers read 0. After release, cmd_ready=1 and the next IN completes normally.

Source files
------------

// File: rtl/seq_datapath_pkg.sv
// Shared encodings for the sequenced datapath: opcodes, sequencer states and
// internal bus source selects, plus small opcode classification helpers.
package seq_datapath_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_IN   = 4'd10;
  localparam logic [3:0] OP_OUT  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOADY = 3'd1;
  localparam logic [2:0] ST_ALU   = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_MAR   = 3'd4;
  localparam logic [2:0] ST_MDR   = 3'd5;
  localparam logic [2:0] ST_WAIT  = 3'd6;
  localparam logic [2:0] ST_MEMWB = 3'd7;

  localparam logic [3:0] BUS_ZERO = 4'd0;
  localparam logic [3:0] BUS_RB   = 4'd1;
  localparam logic [3:0] BUS_RC   = 4'd2;
  localparam logic [3:0] BUS_IMM  = 4'd3;
  localparam logic [3:0] BUS_ZLO  = 4'd4;
  localparam logic [3:0] BUS_MDR  = 4'd5;
  localparam logic [3:0] BUS_IN   = 4'd6;
  localparam logic [3:0] BUS_HI   = 4'd7;
  localparam logic [3:0] BUS_LO   = 4'd8;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_MFLO;
  endfunction

  // Moves and undefined opcodes skip the Y/Z steps and go straight to WB.
  function automatic logic single_step(input logic [3:0] op);
    return op >= OP_IN;
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/seq_datapath_alu.sv
// Combinational ALU: combines Y with the bus value into a double-width Z.
// Only MUL populates the upper half; every other op leaves it zero.
module seq_datapath_alu
  import seq_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]              op,
  input  logic [DATA_WIDTH-1:0]   y,
  input  logic [DATA_WIDTH-1:0]   bus,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]                shamt;
  logic signed [2*DATA_WIDTH-1:0] y_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;

  assign shamt = bus[SHW-1:0];
  assign y_ext = {{DATA_WIDTH{y[DATA_WIDTH-1]}}, y};
  assign b_ext = {{DATA_WIDTH{bus[DATA_WIDTH-1]}}, bus};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: result[DATA_WIDTH-1:0] = y + bus;
      OP_SUB: result[DATA_WIDTH-1:0] = y - bus;
      OP_AND: result[DATA_WIDTH-1:0] = y & bus;
      OP_OR:  result[DATA_WIDTH-1:0] = y | bus;
      OP_SHL: result[DATA_WIDTH-1:0] = y << shamt;
      OP_SHR: result[DATA_WIDTH-1:0] = y >> shamt;
      OP_MUL: result = y_ext * b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus register datapath with a micro-step sequencer; runs one command
// at a time and signals completion with a registered done pulse.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [REG_AW-1:0]     cmd_ra,
  input  logic [REG_AW-1:0]     cmd_rb,
  input  logic [REG_AW-1:0]     cmd_rc,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] inport_data,
  output logic [DATA_WIDTH-1:0] outport_data,
  output logic                  done,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] hi_value,
  output logic [DATA_WIDTH-1:0] lo_value,
  output logic [DATA_WIDTH-1:0] bus_value,
  input  logic [REG_AW-1:0]     dbg_rsel,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [2:0]            dbg_state
);

  logic [2:0]              state;
  logic [3:0]              op_q;
  logic [REG_AW-1:0]       ra_q, rb_q, rc_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [DATA_WIDTH-1:0]   gpr [NUM_REGS];
  logic [DATA_WIDTH-1:0]   y, mar, mdr;
  logic [2*DATA_WIDTH-1:0] z, alu_result;
  logic [3:0]              bus_sel;
  logic [DATA_WIDTH-1:0]   bus;

  // Command handshake: a command transfers on a rising edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is high only in IDLE, and the
  // source must hold the command stable until that transfer.
  assign cmd_ready = (state == ST_IDLE);
  assign mem_rd    = (state == ST_WAIT) && (op_q == OP_LD);
  assign mem_wr    = (state == ST_WAIT) && (op_q == OP_ST);
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign bus_value = bus;
  assign dbg_rdata = gpr[dbg_rsel];
  assign dbg_state = state;

  always_comb begin
    bus_sel = BUS_ZERO;
    case (state)
      ST_LOADY: bus_sel = BUS_RB;
      ST_ALU:   bus_sel = uses_imm(op_q) ? BUS_IMM : BUS_RC;
      ST_MAR:   bus_sel = BUS_ZLO;
      ST_MDR:   bus_sel = BUS_RC;
      ST_MEMWB: bus_sel = BUS_MDR;
      ST_WB: begin
        case (op_q)
          OP_IN:   bus_sel = BUS_IN;
          OP_OUT:  bus_sel = BUS_RB;
          OP_MFHI: bus_sel = BUS_HI;
          OP_MFLO: bus_sel = BUS_LO;
          default: bus_sel = is_legal(op_q) ? BUS_ZLO : BUS_ZERO;
        endcase
      end
      default: bus_sel = BUS_ZERO;
    endcase
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_RB:  bus = gpr[rb_q];
      BUS_RC:  bus = gpr[rc_q];
      BUS_IMM: bus = imm_q;
      BUS_ZLO: bus = z[DATA_WIDTH-1:0];
      BUS_MDR: bus = mdr;
      BUS_IN:  bus = inport_data;
      BUS_HI:  bus = hi_value;
      BUS_LO:  bus = lo_value;
      default: bus = '0;
    endcase
  end

  seq_datapath_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .y      (y),
    .bus    (bus),
    .result (alu_result)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      imm_q        <= '0;
      gpr          <= '{default: '0};
      y            <= '0;
      z            <= '0;
      mar          <= '0;
      mdr          <= '0;
      hi_value     <= '0;
      lo_value     <= '0;
      outport_data <= '0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            rc_q  <= cmd_rc;
            imm_q <= cmd_imm;
            state <= single_step(cmd_op) ? ST_WB : ST_LOADY;
          end
        end
        ST_LOADY: begin
          y     <= bus;
          state <= ST_ALU;
        end
        ST_ALU: begin
          z     <= alu_result;
          state <= (op_q == OP_LD || op_q == OP_ST) ? ST_MAR : ST_WB;
        end
        ST_MAR: begin
          mar   <= bus;
          state <= (op_q == OP_ST) ? ST_MDR : ST_WAIT;
        end
        ST_MDR: begin
          mdr   <= bus;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (op_q == OP_LD) begin
              mdr   <= mem_rdata;
              state <= ST_MEMWB;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_MEMWB: begin
          gpr[ra_q] <= bus;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_WB: begin
          done    <= 1'b1;
          illegal <= !is_legal(op_q);
          state   <= ST_IDLE;
          case (op_q)
            OP_MUL: begin
              hi_value <= z[2*DATA_WIDTH-1:DATA_WIDTH];
              lo_value <= z[DATA_WIDTH-1:0];
            end
            OP_OUT:  outport_data <= bus;
            default: if (is_legal(op_q)) gpr[ra_q] <= bus;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed vector table, reset-abort sequence and a
// randomized command stream checked against a behavioural model.
module tb_seq_datapath;

  logic        clock, clear;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op, cmd_ra, cmd_rb, cmd_rc;
  logic [31:0] cmd_imm;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic [31:0] inport_data, outport_data;
  logic        done, illegal;
  logic [31:0] hi_value, lo_value, bus_value;
  logic [3:0]  dbg_rsel;
  logic [31:0] dbg_rdata;
  logic [2:0]  dbg_state;

  seq_datapath #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clock(clock), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc), .cmd_imm(cmd_imm),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inport_data(inport_data), .outport_data(outport_data),
    .done(done), .illegal(illegal), .hi_value(hi_value), .lo_value(lo_value),
    .bus_value(bus_value), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_gpr [16];
  logic [31:0] m_hi, m_lo, m_out;
  logic [31:0] mem [logic [31:0]];

  int          e_lat, e_rd, e_wr;
  logic [31:0] e_addr, e_wdata;
  logic        e_ill;

  int          o_lat, o_rd, o_wr;
  logic [31:0] o_addr, o_wdata;
  logic        o_ill, o_stable;

  typedef struct {
    logic [3:0]  op, ra, rb, rc;
    logic [31:0] imm, inp;
    int          dly;
    logic [31:0] rdata;
    int          lat, rd_n, wr_n;
    logic [31:0] addr, wdata;
    logic [3:0]  chk_idx;
    logic [31:0] chk_val;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_out = '0;
    mem.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    clear = 1'b0; cmd_valid = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] val);
    dbg_rsel = idx;
    #1 val = dbg_rdata;
  endtask

  task automatic sweep_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 16; i++) exp_q.push_back(m_gpr[i]);
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check(tag, v, exp_q.pop_front());
    end
  endtask

  // Issues one command at a negedge, services the memory handshake with the
  // given ack delay and records latency / strobe observations.
  task automatic run_cmd(input logic [3:0] op, ra, rb, rc, input logic [31:0] imm, inp,
                         input int dly, input logic [31:0] rdata, input bit noise);
    int wait_n, cyc, strobes;
    o_lat = -1; o_rd = 0; o_wr = 0; o_addr = '0; o_wdata = '0; o_ill = 1'b0; o_stable = 1'b1;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
    inport_data = inp; cmd_valid = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 20) begin
      @(negedge clock);
      wait_n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    cyc = 0; strobes = 0;
    while (cyc < 60) begin
      @(negedge clock);
      cyc++;
      cmd_valid = 1'b0;
      if (mem_rd || mem_wr) begin
        if (strobes == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata) begin
          o_stable = 1'b0;
        end
        strobes++;
        if (mem_rd) o_rd++;
        if (mem_wr) o_wr++;
        mem_ack   = (strobes == dly + 1);
        mem_rdata = mem_ack ? rdata : $urandom;
      end else begin
        mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      if (done) begin
        o_lat = cyc;
        o_ill = illegal;
        break;
      end
    end
    if (o_lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- reference model ----------------
  task automatic model_cmd(input logic [3:0] op, ra, rb, rc, input logic [31:0] imm, inp,
                           input int dly, input logic [31:0] rdata);
    logic [31:0] a, b;
    longint p;
    a = m_gpr[rb]; b = m_gpr[rc];
    e_lat = 4; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_ill = 1'b0;
    case (op)
      4'd0: m_gpr[ra] = a + b;
      4'd1: m_gpr[ra] = a - b;
      4'd2: m_gpr[ra] = a & b;
      4'd3: m_gpr[ra] = a | b;
      4'd4: m_gpr[ra] = a << b[4:0];
      4'd5: m_gpr[ra] = a >> b[4:0];
      4'd6: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd7: m_gpr[ra] = a + imm;
      4'd8: begin
        e_lat = 6 + dly; e_rd = dly + 1; e_addr = a + imm;
        m_gpr[ra] = rdata;
      end
      4'd9: begin
        e_lat = 6 + dly; e_wr = dly + 1; e_addr = a + imm; e_wdata = b;
        mem[e_addr] = b;
      end
      4'd10: begin e_lat = 2; m_gpr[ra] = inp; end
      4'd11: begin e_lat = 2; m_out = a; end
      4'd12: begin e_lat = 2; m_gpr[ra] = m_hi; end
      4'd13: begin e_lat = 2; m_gpr[ra] = m_lo; end
      default: begin e_lat = 2; e_ill = 1'b1; end
    endcase
  endtask

  function automatic vec_t mk(input logic [3:0] op, ra, rb, rc, input logic [31:0] imm, inp,
                              input int dly, input logic [31:0] rdata, input int lat, rd_n, wr_n,
                              input logic [31:0] addr, wdata, input logic [3:0] chk_idx,
                              input logic [31:0] chk_val, input logic ill);
    vec_t v;
    v.op = op; v.ra = ra; v.rb = rb; v.rc = rc; v.imm = imm; v.inp = inp;
    v.dly = dly; v.rdata = rdata; v.lat = lat; v.rd_n = rd_n; v.wr_n = wr_n;
    v.addr = addr; v.wdata = wdata; v.chk_idx = chk_idx; v.chk_val = chk_val; v.ill = ill;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v, rdata, addr;
    bit seen;
    logic [3:0] op, ra, rb, rc;
    logic [31:0] imm, inp;
    int dly;

    clear = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
    cmd_imm = '0; mem_ack = 1'b0; mem_rdata = '0; inport_data = '0; dbg_rsel = '0;

    // Reset state
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_hi", hi_value, 0);
    check("rst_lo", lo_value, 0);
    check("rst_outport", outport_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    sweep_regs("rst_gpr");
    @(negedge clock);
    clear = 1'b1;

    // Directed vectors, issued back-to-back (each accepted in the previous done cycle)
    //                op     ra    rb    rc    imm         inp          dly rdata        lat rd wr addr        wdata        chk  val          ill
    tbl.push_back(mk(4'd10, 4'd1, 4'd0, 4'd0, 32'h0,      32'h5,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd1, 32'h5,       0));
    tbl.push_back(mk(4'd10, 4'd2, 4'd0, 4'd0, 32'h0,      32'hFFFFFFFE, 0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd2, 32'hFFFFFFFE, 0));
    tbl.push_back(mk(4'd0,  4'd3, 4'd1, 4'd2, 32'h0,      32'h0,        0, 32'h0,        4, 0, 0, 32'h0,      32'h0,       4'd3, 32'h3,       0));
    tbl.push_back(mk(4'd1,  4'd4, 4'd1, 4'd2, 32'h0,      32'h0,        0, 32'h0,        4, 0, 0, 32'h0,      32'h0,       4'd4, 32'h7,       0));
    tbl.push_back(mk(4'd10, 4'd1, 4'd0, 4'd0, 32'h0,      32'hFFFFFFFD, 0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd1, 32'hFFFFFFFD, 0));
    tbl.push_back(mk(4'd10, 4'd2, 4'd0, 4'd0, 32'h0,      32'h7,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd2, 32'h7,       0));
    tbl.push_back(mk(4'd6,  4'd8, 4'd1, 4'd2, 32'h0,      32'h0,        0, 32'h0,        4, 0, 0, 32'h0,      32'h0,       4'd8, 32'h0,       0));
    tbl.push_back(mk(4'd12, 4'd5, 4'd0, 4'd0, 32'h0,      32'h0,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd5, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(4'd13, 4'd6, 4'd0, 4'd0, 32'h0,      32'h0,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd6, 32'hFFFFFFEB, 0));
    tbl.push_back(mk(4'd10, 4'd1, 4'd0, 4'd0, 32'h0,      32'h5,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd1, 32'h5,       0));
    tbl.push_back(mk(4'd10, 4'd2, 4'd0, 4'd0, 32'h0,      32'hCAFEF00D, 0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd2, 32'hCAFEF00D, 0));
    tbl.push_back(mk(4'd9,  4'd0, 4'd1, 4'd2, 32'h10,     32'h0,        3, 32'h0,        9, 0, 4, 32'h15,     32'hCAFEF00D, 4'd2, 32'hCAFEF00D, 0));
    tbl.push_back(mk(4'd8,  4'd7, 4'd1, 4'd0, 32'h10,     32'h0,        0, 32'hDEADBEEF, 6, 1, 0, 32'h15,     32'hCAFEF00D, 4'd7, 32'hDEADBEEF, 0));
    tbl.push_back(mk(4'd10, 4'd1, 4'd0, 4'd0, 32'h0,      32'h1,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd1, 32'h1,       0));
    tbl.push_back(mk(4'd10, 4'd2, 4'd0, 4'd0, 32'h0,      32'h21,       0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd2, 32'h21,      0));
    tbl.push_back(mk(4'd4,  4'd3, 4'd1, 4'd2, 32'h0,      32'h0,        0, 32'h0,        4, 0, 0, 32'h0,      32'h0,       4'd3, 32'h2,       0));
    tbl.push_back(mk(4'd15, 4'd3, 4'd1, 4'd2, 32'h0,      32'h0,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd3, 32'h2,       1));
    tbl.push_back(mk(4'd11, 4'd0, 4'd3, 4'd0, 32'h0,      32'h0,        0, 32'h0,        2, 0, 0, 32'h0,      32'h0,       4'd3, 32'h2,       0));
    tbl.push_back(mk(4'd7,  4'd9, 4'd2, 4'd0, 32'hFFFFFFFF, 32'h0,      1, 32'h0,        4, 0, 0, 32'h0,      32'h0,       4'd9, 32'h20,      0));

    for (int i = 0; i < tbl.size(); i++) begin
      check("tbl_ready", cmd_ready, 1);
      run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm, tbl[i].inp,
              tbl[i].dly, tbl[i].rdata, 1'b0);
      check($sformatf("tbl%0d_latency", i), o_lat, tbl[i].lat);
      check($sformatf("tbl%0d_illegal", i), o_ill, tbl[i].ill);
      check($sformatf("tbl%0d_rd_cycles", i), o_rd, tbl[i].rd_n);
      check($sformatf("tbl%0d_wr_cycles", i), o_wr, tbl[i].wr_n);
      if (tbl[i].rd_n + tbl[i].wr_n > 0) begin
        check($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
        check($sformatf("tbl%0d_wdata", i), o_wdata, tbl[i].wdata);
        check($sformatf("tbl%0d_stable", i), o_stable, 1);
      end
      read_reg(tbl[i].chk_idx, v);
      check($sformatf("tbl%0d_reg", i), v, tbl[i].chk_val);
    end
    check("tbl_hi", hi_value, 32'hFFFFFFFF);
    check("tbl_lo", lo_value, 32'hFFFFFFEB);
    check("tbl_outport", outport_data, 32'h2);

    // Reset asserted while a load is waiting for memory
    @(negedge clock);
    run_cmd(4'd10, 4'd1, 4'd0, 4'd0, 32'h0, 32'h40, 0, 32'h0, 1'b0);
    check("abort_setup_latency", o_lat, 2);
    cmd_op = 4'd8; cmd_ra = 4'd7; cmd_rb = 4'd1; cmd_rc = 4'd0; cmd_imm = 32'h0;
    cmd_valid = 1'b1; mem_ack = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (mem_rd) seen = 1'b1;
    end
    check("abort_rd_seen", seen, 1);
    check("abort_addr", mem_addr, 32'h40);
    repeat (2) @(negedge clock);
    check("abort_rd_held", mem_rd, 1);
    #2 clear = 1'b0;
    #1;
    check("abort_mem_rd", mem_rd, 0);
    check("abort_mem_wr", mem_wr, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_hi", hi_value, 0);
    check("abort_lo", lo_value, 0);
    check("abort_outport", outport_data, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    model_reset();
    sweep_regs("abort_gpr");
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("abort_ready_after", cmd_ready, 1);
    run_cmd(4'd10, 4'd2, 4'd0, 4'd0, 32'h0, 32'h1234, 0, 32'h0, 1'b0);
    check("abort_in_latency", o_lat, 2);
    read_reg(4'd2, v);
    check("abort_in_r2", v, 32'h1234);
    read_reg(4'd1, v);
    check("abort_in_r1", v, 32'h0);

    // Randomized command stream against the behavioural model
    @(negedge clock);
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      op  = (n < 16) ? 4'd10 : 4'($urandom_range(0, 15));
      ra  = (n < 16) ? 4'(n) : 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 4'($urandom_range(0, 15));
      imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
      inp = $urandom;
      dly = $urandom_range(0, 3);
      rdata = $urandom;
      if (op == 4'd8) begin
        addr = m_gpr[rb] + imm;
        if (mem.exists(addr)) rdata = mem[addr];
      end
      model_cmd(op, ra, rb, rc, imm, inp, dly, rdata);
      run_cmd(op, ra, rb, rc, imm, inp, dly, rdata, 1'b1);
      check("rnd_latency", o_lat, e_lat);
      check("rnd_illegal", o_ill, e_ill);
      check("rnd_rd_cycles", o_rd, e_rd);
      check("rnd_wr_cycles", o_wr, e_wr);
      if (e_rd + e_wr > 0) begin
        check("rnd_addr", o_addr, e_addr);
        check("rnd_stable", o_stable, 1);
      end
      if (e_wr > 0) check("rnd_wdata", o_wdata, e_wdata);
      read_reg(ra, v);
      check($sformatf("rnd%0d_op%0d_r%0d", n, op, ra), v, m_gpr[ra]);
      check("rnd_hi", hi_value, m_hi);
      check("rnd_lo", lo_value, m_lo);
      check("rnd_outport", outport_data, m_out);
      if (n % 50 == 49) begin
        sweep_regs("rnd_gpr_sweep");
        @(negedge clock);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
